seq_mult5_ctrl: RTL and testbench
=================================

Name: seq_mult5_ctrl

Overview:
- Multi-cycle sequencer for the 5-bit multiplier datapath. It computes an unsigned WIDTH x WIDTH product by radix-2 shift-and-add, time-sharing one (WIDTH+1)-bit adder slice.
- Sits between the operand source and the product consumer.
- Input side uses a start/ready handshake. Output side uses a valid/ack handshake with the result held until acknowledged.

Parameters:
- WIDTH, 5, operand width in bits. Product is 2*WIDTH bits. Iteration count is WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset. Clears all state immediately.
- start  input  1  request to multiply a_in by b_in. Accepted only when ready=1.
- a_in  input  WIDTH  multiplicand, sampled on the accepting edge.
- b_in  input  WIDTH  multiplier, sampled on the accepting edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN only.
- prod_valid  output  1  high in DONE only.
- prod_ack  input  1  consumer acknowledge. Meaningful only while prod_valid=1.
- product  output  2*WIDTH  unsigned product. Registered.
- step_cnt  output  3  iterations completed in the current RUN, 0..WIDTH. Debug/observability.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, ready=1, busy=0, prod_valid=0, product=0, step_cnt=0, internal acc/mcand/mult registers=0.
- Reset asserted mid-RUN or mid-DONE: aborts immediately, no partial product is published. First cycle after release is IDLE.
- Internal registers:
  - mcand[WIDTH-1:0]
  - acc_hi[WIDTH-1:0], acc_lo[WIDTH-1:0], where acc_lo doubles as the multiplier shift register
  - cnt[2:0]
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 on an edge: mcand<=a_in, acc_lo<=b_in, acc_hi<=0, cnt<=0, go to RUN.
  - Otherwise stay in IDLE. product holds its previous value.
- RUN, one iteration per clock:
  - sum[WIDTH:0] = {1'b0,acc_hi} + (acc_lo[0] ? {1'b0,mcand} : 0). The adder is exactly WIDTH+1 bits wide and never overflows.
  - Then {acc_hi,acc_lo} <= {sum, acc_lo[WIDTH-1:1]}, i.e. the WIDTH+1-bit sum concatenated with acc_lo shifted right by one.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 on the edge: product<={sum, acc_lo[WIDTH-1:1]}, state<=DONE.
- Latency: accepting edge E0, then iteration edges E1..EWIDTH. prod_valid is high from just after edge EWIDTH, i.e. WIDTH cycles after acceptance.
- Latency is fixed and independent of operand values. Zero operands still take WIDTH cycles.
- DONE:
  - prod_valid=1, product stable.
  - On an edge with prod_ack=1: go to IDLE. prod_valid drops, ready rises the next cycle, product is still held.
  - Without prod_ack, DONE is held indefinitely.
- Start handling:
  - start while busy or prod_valid is ignored and not queued.
  - start and prod_ack high on the same edge in DONE: only the ack is taken. The start must be re-presented in IDLE.
- Input stability: a_in and b_in are don't-care except on the accepting edge.
- step_cnt: equals cnt in RUN. Reads WIDTH in DONE and 0 in IDLE.
- Width rule: product = a_in*b_in exactly, with maximum (2^WIDTH-1)^2 = 961 for WIDTH=5.

Test Plan:
- Reset then start with a_in=5, b_in=6 -> ready drops next cycle, busy for exactly 5 cycles, prod_valid after 5 cycles, product=30. With prod_ack high, ready=1 the cycle after.
- Corner operands: a_in=31, b_in=31 -> product=961 (0x3C1). a_in=0, b_in=17 -> product=0, still 5 cycles. a_in=31, b_in=1 -> 31. a_in=1, b_in=31 -> 31.
- Hold the ack low for 10 cycles in DONE while toggling a_in, b_in and start -> product and prod_valid stay constant and no new operation starts. The ack then returns the block to IDLE.
- Pulse start at RUN cycle 2 with different operands -> ignored, the original result is produced. Assert start and prod_ack together in DONE -> IDLE with no new run started.
- Assert rst_n=0 asynchronously at RUN cycle 3 (operands 7x9) -> ready=1, prod_valid=0 and product=0 immediately. After release a new 3x4 run yields 12.
- Back-to-back: 100 random operand pairs, each acknowledged on the first valid cycle -> each product matches a*b and each transaction takes exactly WIDTH+2 cycles start-to-ready.

Source files
------------

// File: rtl/seq_mult5_ctrl_if.sv
// Operand/product handshake bundle for the shift-and-add multiplier sequencer.
// master: operand source and product consumer; slave: the sequencer.
interface seq_mult5_ctrl_if #(
  parameter int unsigned WIDTH = 5
);
  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               ready;
  logic               busy;
  logic               prod_valid;
  logic               prod_ack;
  logic [2*WIDTH-1:0] product;
  logic [2:0]         step_cnt;

  modport master (
    output start, a_in, b_in, prod_ack,
    input  ready, busy, prod_valid, product, step_cnt
  );

  modport slave (
    input  start, a_in, b_in, prod_ack,
    output ready, busy, prod_valid, product, step_cnt
  );
endinterface

// File: rtl/seq_mult5_ctrl.sv
// Radix-2 shift-and-add multiplier sequencer: one WIDTH+1 bit adder slice reused
// over WIDTH iterations, start/ready on the operand side, valid/ack on the product side.
module seq_mult5_ctrl #(
  parameter int unsigned WIDTH = 5
) (
  input logic             clk,
  input logic             rst_n,
  seq_mult5_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [2:0] LastIter = 3'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;  // low product half, also the multiplier shift register
  logic [2:0]       cnt_q;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
  end

  assign bus.step_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      mcand_q        <= '0;
      acc_hi_q       <= '0;
      acc_lo_q       <= '0;
      cnt_q          <= '0;
      bus.ready      <= 1'b1;
      bus.busy       <= 1'b0;
      bus.prod_valid <= 1'b0;
      bus.product    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            mcand_q   <= bus.a_in;
            acc_lo_q  <= bus.b_in;
            acc_hi_q  <= '0;
            cnt_q     <= '0;
            state_q   <= StRun;
            bus.ready <= 1'b0;
            bus.busy  <= 1'b1;
          end
        end
        StRun: begin
          {acc_hi_q, acc_lo_q} <= {sum, acc_lo_q[WIDTH-1:1]};
          cnt_q                <= cnt_q + 3'd1;
          if (cnt_q == LastIter) begin
            bus.product    <= {sum, acc_lo_q[WIDTH-1:1]};
            state_q        <= StDone;
            bus.busy       <= 1'b0;
            bus.prod_valid <= 1'b1;
          end
        end
        StDone: begin
          // A start arriving with the ack is dropped; it must be re-presented in idle.
          if (bus.prod_ack) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            bus.prod_valid <= 1'b0;
            bus.ready      <= 1'b1;
          end
        end
        default: begin
          state_q        <= StIdle;
          bus.ready      <= 1'b1;
          bus.busy       <= 1'b0;
          bus.prod_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult5_ctrl.sv
// Self-checking bench for seq_mult5_ctrl: vector table, hand-written corner sequences
// and random transactions against a plain-arithmetic product/latency model.
module tb_seq_mult5_ctrl;

  localparam int unsigned W = 5;
  localparam int unsigned MaxOp = (1 << W) - 1;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned prod;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[7];

  seq_mult5_ctrl_if #(.WIDTH(W)) bus ();

  seq_mult5_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands, take the accepting edge, then wait until the product is valid.
  // Returns the number of busy cycles observed.
  task automatic accept_and_run(input int unsigned a, input int unsigned b,
                                input string nm, output int busy_cycles);
    int k;
    bus.a_in  = W'(a);
    bus.b_in  = W'(b);
    bus.start = 1'b1;
    chk({nm, " ready before start"}, int'(bus.ready), 1);
    step();
    bus.start = 1'b0;
    bus.a_in  = W'($urandom);
    bus.b_in  = W'($urandom);
    chk({nm, " ready after accept"}, int'(bus.ready), 0);
    k = 0;
    while (bus.busy && k < 20) begin
      chk({nm, " step_cnt"}, int'(bus.step_cnt), k);
      chk({nm, " valid during run"}, int'(bus.prod_valid), 0);
      step();
      k++;
    end
    busy_cycles = k;
    chk({nm, " busy cycles"}, k, int'(W));
  endtask

  // Full transaction with ack on the first valid cycle.
  task automatic run_txn(input int unsigned a, input int unsigned b,
                         input int unsigned exp, input string nm);
    int busy_cycles;
    int latency;
    accept_and_run(a, b, nm, busy_cycles);
    chk({nm, " prod_valid"}, int'(bus.prod_valid), 1);
    chk({nm, " product"}, int'(bus.product), int'(exp));
    chk({nm, " step_cnt done"}, int'(bus.step_cnt), int'(W));
    chk({nm, " ready in done"}, int'(bus.ready), 0);
    bus.prod_ack = 1'b1;
    step();
    bus.prod_ack = 1'b0;
    latency = 1 + busy_cycles + 1;
    chk({nm, " ready after ack"}, int'(bus.ready), 1);
    chk({nm, " valid after ack"}, int'(bus.prod_valid), 0);
    chk({nm, " product held"}, int'(bus.product), int'(exp));
    chk({nm, " step_cnt idle"}, int'(bus.step_cnt), 0);
    chk({nm, " start-to-ready"}, latency, int'(W) + 2);
  endtask

  initial begin
    int bc;
    int unsigned ra;
    int unsigned rb;
    checks = 0;
    errors = 0;
    vecs[0] = '{a: 5,  b: 6,  prod: 30};
    vecs[1] = '{a: 31, b: 31, prod: 961};
    vecs[2] = '{a: 0,  b: 17, prod: 0};
    vecs[3] = '{a: 31, b: 1,  prod: 31};
    vecs[4] = '{a: 1,  b: 31, prod: 31};
    vecs[5] = '{a: 7,  b: 9,  prod: 63};
    vecs[6] = '{a: 17, b: 0,  prod: 0};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.a_in     = '0;
    bus.b_in     = '0;
    bus.prod_ack = 1'b0;
    step();
    step();
    chk("reset ready", int'(bus.ready), 1);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset valid", int'(bus.prod_valid), 0);
    chk("reset product", int'(bus.product), 0);
    chk("reset step_cnt", int'(bus.step_cnt), 0);
    rst_n = 1'b1;
    step();
    chk("idle after release", int'(bus.ready), 1);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i));
    end

    // Ack withheld for 10 cycles while inputs and start toggle.
    accept_and_run(13, 11, "hold", bc);
    for (int i = 0; i < 10; i++) begin
      bus.a_in  = W'($urandom);
      bus.b_in  = W'($urandom);
      bus.start = ~bus.start;
      step();
      chk("hold valid", int'(bus.prod_valid), 1);
      chk("hold product", int'(bus.product), 143);
      chk("hold busy", int'(bus.busy), 0);
    end
    bus.start    = 1'b0;
    bus.prod_ack = 1'b1;
    step();
    bus.prod_ack = 1'b0;
    chk("hold ack ready", int'(bus.ready), 1);
    chk("hold ack valid", int'(bus.prod_valid), 0);

    // Start pulsed mid-run is ignored.
    bus.a_in  = W'(6);
    bus.b_in  = W'(7);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.a_in  = W'(31);
    bus.b_in  = W'(31);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 20 && !bus.prod_valid; i++) step();
    chk("midrun start valid", int'(bus.prod_valid), 1);
    chk("midrun start product", int'(bus.product), 42);

    // Start together with ack in done: only the ack is taken.
    bus.a_in     = W'(2);
    bus.b_in     = W'(2);
    bus.start    = 1'b1;
    bus.prod_ack = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.prod_ack = 1'b0;
    chk("start+ack ready", int'(bus.ready), 1);
    chk("start+ack busy", int'(bus.busy), 0);
    step();
    chk("start+ack no run", int'(bus.busy), 0);
    chk("start+ack still idle", int'(bus.ready), 1);
    chk("start+ack product", int'(bus.product), 42);

    // Asynchronous reset at run cycle 3 discards the partial product.
    bus.a_in  = W'(7);
    bus.b_in  = W'(9);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    chk("pre-reset step_cnt", int'(bus.step_cnt), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset ready", int'(bus.ready), 1);
    chk("async reset busy", int'(bus.busy), 0);
    chk("async reset valid", int'(bus.prod_valid), 0);
    chk("async reset product", int'(bus.product), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post-reset idle", int'(bus.ready), 1);
    run_txn(3, 4, 12, "post-reset");

    for (int i = 0; i < 100; i++) begin
      ra = $urandom_range(0, MaxOp);
      rb = $urandom_range(0, MaxOp);
      run_txn(ra, rb, ra * rb, $sformatf("rnd%0d %0dx%0d", i, ra, rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
